// File: rtl/led_matrix_scan_pkg.sv
// Shared 8x8 board types and row extraction, common to the shift stage and the scanner.
package matrix_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 8;

  typedef logic [ROWS*COLS-1:0] frame_t;
  typedef logic [COLS-1:0]      line_t;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  // Row 0 lives in the top byte; bit 7 of each line is the leftmost column.
  function automatic line_t row_of(frame_t f, int r);
    return f[(ROWS-1-r)*COLS +: COLS];
  endfunction

endpackage

// File: rtl/led_matrix_scan_if.sv
// Frame handoff from the shift stage: valid/ready transfer of one 64-bit board.
interface led_matrix_scan_if;
  import matrix_pkg::*;

  frame_t frame_in;
  logic   frame_valid;
  logic   frame_ready;

  modport master (output frame_in, output frame_valid, input frame_ready);
  modport slave  (input frame_in, input frame_valid, output frame_ready);

endinterface

// File: rtl/led_matrix_scan_tick_gen.sv
// Row-slot timebase: tick within a row slot, current row, and end-of-slot / end-of-frame strobes.
module scan_tick_gen
  import matrix_pkg::*;
#(
  parameter  int ROW_TICKS = 1000,
  localparam int TW        = (ROW_TICKS > 1) ? $clog2(ROW_TICKS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic [TW-1:0] tick,
  output logic [2:0]    row,
  output logic          last_tick,
  output logic          frame_end
);

  assign last_tick = (tick == TW'(ROW_TICKS - 1));
  assign frame_end = last_tick && (row == 3'(ROWS - 1));

  // Row wraps 7 -> 0 through natural 3-bit overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick <= '0;
      row  <= '0;
    end else if (last_tick) begin
      tick <= '0;
      row  <= row + 3'd1;
    end else begin
      tick <= tick + TW'(1);
    end
  end

endmodule

// File: rtl/led_matrix_scan.sv
// Double-buffered 8x8 LED row-multiplexing driver with per-row anti-ghosting blanking.
//   state    | meaning
//   ST_BLANK | first BLANK_TICKS ticks of a row slot, all rows and columns off
//   ST_DRIVE | remainder of the slot, current row selected and its columns driven
module led_matrix_scan
  import matrix_pkg::*;
#(
  parameter int ROW_TICKS      = 1000,
  parameter int BLANK_TICKS    = 8,
  parameter bit ROW_ACTIVE_LOW = 1'b1,
  parameter bit COL_ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  led_matrix_scan_if.slave    bus,
  output line_t               row_sel,
  output line_t               col_data,
  output logic                frame_done
);

  localparam int    TW      = (ROW_TICKS > 1) ? $clog2(ROW_TICKS) : 1;
  localparam line_t ROW_OFF = ROW_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam line_t COL_OFF = COL_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [TW-1:0] tick;
  logic [2:0]    row;
  logic          last_tick;
  logic          frame_end;

  frame_t        active;
  frame_t        pending;
  logic          pending_full;

  scan_state_t   state_q;
  scan_state_t   state_d;
  line_t         row_sel_d;
  line_t         col_data_d;

  scan_tick_gen #(.ROW_TICKS(ROW_TICKS)) u_tick_gen (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .row       (row),
    .last_tick (last_tick),
    .frame_end (frame_end)
  );

  // Swap wins over acceptance: ready is already low whenever a swap can happen.
  always_ff @(posedge clk) begin
    if (reset) begin
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
    end else if (frame_end && pending_full) begin
      active       <= pending;
      pending_full <= 1'b0;
    end else if (bus.frame_valid && !pending_full) begin
      pending      <= bus.frame_in;
      pending_full <= 1'b1;
    end
  end

  assign bus.frame_ready = ~pending_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BLANK;
    end else begin
      state_q <= state_d;
    end
  end

  // state_q tracks the phase of the current tick, so look one tick ahead here.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (!last_tick && (int'(tick) + 1 >= BLANK_TICKS)) state_d = ST_DRIVE;
      ST_DRIVE: if (last_tick) state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase
  end

  always_comb begin
    row_sel_d  = ROW_OFF;
    col_data_d = COL_OFF;
    if (state_q == ST_DRIVE) begin
      row_sel_d  = ROW_ACTIVE_LOW ? ~(line_t'(1) << row) : (line_t'(1) << row);
      col_data_d = COL_ACTIVE_LOW ? ~row_of(active, int'(row)) : row_of(active, int'(row));
    end
  end

  // Column data is captured from the pre-swap buffer, so row 7 never shows the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_sel    <= ROW_OFF;
      col_data   <= COL_OFF;
      frame_done <= 1'b0;
    end else begin
      row_sel    <= row_sel_d;
      col_data   <= col_data_d;
      frame_done <= frame_end;
    end
  end

endmodule
